// File: rtl/autoconfig_pkg.sv
// Shared constants, state encodings and size decoding for the Zorro II AutoConfig host.
package autoconfig_pkg;

   // A23:A1 of $E80000; nibble n of the config ROM sits at word offset n
   localparam logic [22:0] AC_BASE_ADDR  = 23'h740000;
   localparam logic [4:0]  NIB_TYPE      = 5'd0;
   localparam logic [4:0]  NIB_PRODUCT   = 5'd2;
   localparam logic [4:0]  NIB_MFG       = 5'd8;
   localparam logic [4:0]  NIB_SERIAL    = 5'd12;
   localparam logic [6:0]  AC_BASE_REG   = 7'h24;
   localparam logic [6:0]  AC_SHUTUP_REG = 7'h26;
   localparam logic [3:0]  AC_FIRST_SLOT = 4'd2;
   localparam logic [4:0]  AC_SLOT_LIMIT = 5'd10;

   localparam logic [2:0]  SZ_8M = 3'b000;
   localparam logic [2:0]  SZ_2M = 3'b110;
   localparam logic [2:0]  SZ_4M = 3'b111;

   typedef enum logic [2:0] {
      StIdle, StReadRom, StDecide, StWrite, StReport, StFinish
   } acState_e;

   typedef enum logic [2:0] {
      BusIdle, BusC0, BusC1, BusC2, BusWait, BusC3, BusC4, BusC5
   } busState_e;

   // 1M slots occupied by a board; 0 means it can never fit the 2M-10M window
   function automatic logic [3:0] slotsFor(input logic [2:0] sizeCode);
      case (sizeCode)
         SZ_8M:   slotsFor = 4'd0;
         SZ_2M:   slotsFor = 4'd2;
         SZ_4M:   slotsFor = 4'd4;
         default: slotsFor = 4'd1;
      endcase
   endfunction

endpackage

// File: rtl/autoconfig_master_if.sv
// 68000-style nibble bus between the AutoConfig host and the board chain.
interface autoconfig_master_if;
   logic        AS_n;
   logic        UDS_n;
   logic        RW;
   logic [22:0] ADDRESS;
   logic [3:0]  DATA_OUT;
   logic        DATA_OE;
   logic [3:0]  DATA_IN;
   logic        DTACK_n;

   modport master (
      output AS_n, UDS_n, RW, ADDRESS, DATA_OUT, DATA_OE,
      input  DATA_IN, DTACK_n
   );

   modport slave (
      input  AS_n, UDS_n, RW, ADDRESS, DATA_OUT, DATA_OE,
      output DATA_IN, DTACK_n
   );
endinterface

// File: rtl/m68k_bus_cycle.sv
// Single 68000 bus cycle engine: strobe sequencing, DTACK synchroniser and DTACK timeout.
module m68k_bus_cycle
   import autoconfig_pkg::*;
#(
   parameter int unsigned DTACK_TIMEOUT = 255
) (
   input  logic        CLK,
   input  logic        RESET_n,
   input  logic        req,
   input  logic        rw,
   input  logic [22:0] addr,
   input  logic [3:0]  wdata,
   output logic        ack,
   output logic        timedOut,
   output logic [3:0]  rdata,
   autoconfig_master_if.master bus
);

   localparam logic [7:0] WaitLimit = 8'(DTACK_TIMEOUT - 1);

   busState_e  state;
   logic       dtackMeta;
   logic       dtackSync;
   logic [7:0] waitCnt;

   // Asynchronous reset returns the strobes high immediately, even mid-cycle
   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         state        <= BusIdle;
         bus.AS_n     <= 1'b1;
         bus.UDS_n    <= 1'b1;
         bus.RW       <= 1'b1;
         bus.ADDRESS  <= '0;
         bus.DATA_OUT <= '0;
         bus.DATA_OE  <= 1'b0;
         dtackMeta    <= 1'b1;
         dtackSync    <= 1'b1;
         waitCnt      <= '0;
         ack          <= 1'b0;
         timedOut     <= 1'b0;
         rdata        <= '0;
      end else begin
         dtackMeta <= bus.DTACK_n;
         dtackSync <= dtackMeta;
         ack       <= 1'b0;
         case (state)
            BusIdle: begin
               if (req) begin
                  bus.ADDRESS  <= addr;
                  bus.RW       <= rw;
                  bus.DATA_OUT <= rw ? 4'h0 : wdata;
                  bus.DATA_OE  <= !rw;
                  timedOut     <= 1'b0;
                  state        <= BusC0;
               end
            end
            BusC0: begin
               bus.AS_n <= 1'b0;
               state    <= BusC1;
            end
            BusC1: begin
               bus.UDS_n <= 1'b0;
               state     <= BusC2;
            end
            BusC2: begin
               waitCnt <= '0;
               state   <= BusWait;
            end
            BusWait: begin
               if (!dtackSync) begin
                  state <= BusC3;
               end else if (waitCnt == WaitLimit) begin
                  bus.AS_n  <= 1'b1;
                  bus.UDS_n <= 1'b1;
                  timedOut  <= 1'b1;
                  state     <= BusC4;
               end else begin
                  waitCnt <= waitCnt + 8'd1;
               end
            end
            BusC3: begin
               rdata     <= bus.DATA_IN;
               bus.AS_n  <= 1'b1;
               bus.UDS_n <= 1'b1;
               state     <= BusC4;
            end
            BusC4: begin
               bus.ADDRESS  <= '0;
               bus.RW       <= 1'b1;
               bus.DATA_OUT <= '0;
               bus.DATA_OE  <= 1'b0;
               state        <= BusC5;
            end
            BusC5: begin
               ack   <= 1'b1;
               state <= BusIdle;
            end
            default: state <= BusIdle;
         endcase
      end
   end

endmodule

// File: rtl/autoconfig_master.sv
// Zorro II AutoConfig host: reads each board's nibble ROM, assigns a 1M base or shuts it up.
// Optional feature AUTOCONFIG_SERIAL_EN: also reads nibbles 12-19 onto CFG_SERIAL.
module autoconfig_master
   import autoconfig_pkg::*;
#(
   parameter int unsigned MAX_BOARDS    = 8,
   parameter int unsigned DTACK_TIMEOUT = 255
) (
   input  logic        CLK,
   input  logic        RESET_n,
   input  logic        START,
   autoconfig_master_if.master bus,
   output logic        CFG_VALID,
   output logic [15:0] CFG_MFG,
   output logic [7:0]  CFG_PRODUCT,
   output logic [3:0]  CFG_BASE,
   output logic [31:0] CFG_SERIAL,
   output logic [3:0]  BOARD_COUNT,
   output logic        BUSY,
   output logic        DONE
);

   localparam logic [3:0] MaxCount = 4'(MAX_BOARDS);
`ifdef AUTOCONFIG_SERIAL_EN
   localparam logic [4:0] NibLast = NIB_SERIAL + 5'd7;
   logic [31:0] serial;
`else
   localparam logic [4:0] NibLast = NIB_SERIAL - 5'd1;
   assign CFG_SERIAL = '0;
`endif

   acState_e    state;
   logic        busReq;
   logic        busRw;
   logic [22:0] busAddr;
   logic [3:0]  busWdata;
   logic        busAck;
   logic        busTimedOut;
   logic [3:0]  busRdata;
   logic        waitAck;
   logic [4:0]  nib;
   logic        faulty;
   logic [2:0]  sizeCode;
   logic [7:0]  product;
   logic [15:0] mfg;
   logic [3:0]  nextBase;
   logic [3:0]  assignedBase;

   logic [3:0]  slots;
   logic [4:0]  aligned;
   logic [4:0]  placedEnd;
   logic        fits;

   m68k_bus_cycle #(
      .DTACK_TIMEOUT(DTACK_TIMEOUT)
   ) u_busCycle (
      .CLK     (CLK),
      .RESET_n (RESET_n),
      .req     (busReq),
      .rw      (busRw),
      .addr    (busAddr),
      .wdata   (busWdata),
      .ack     (busAck),
      .timedOut(busTimedOut),
      .rdata   (busRdata),
      .bus     (bus)
   );

   // Natural alignment: a board is placed on a multiple of its own slot count
   always_comb begin
      slots   = slotsFor(sizeCode);
      aligned = {1'b0, nextBase};
      if (slots == 4'd2) begin
         aligned = ({1'b0, nextBase} + 5'd1) & 5'b11110;
      end else if (slots == 4'd4) begin
         aligned = ({1'b0, nextBase} + 5'd3) & 5'b11100;
      end
      placedEnd = aligned + {1'b0, slots};
      fits      = !faulty && (slots != 4'd0) && (placedEnd <= AC_SLOT_LIMIT);
   end

   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         state        <= StIdle;
         busReq       <= 1'b0;
         busRw        <= 1'b1;
         busAddr      <= '0;
         busWdata     <= '0;
         waitAck      <= 1'b0;
         nib          <= '0;
         faulty       <= 1'b0;
         sizeCode     <= '0;
         product      <= '0;
         mfg          <= '0;
         nextBase     <= AC_FIRST_SLOT;
         assignedBase <= '0;
         CFG_VALID    <= 1'b0;
         CFG_MFG      <= '0;
         CFG_PRODUCT  <= '0;
         CFG_BASE     <= '0;
         BOARD_COUNT  <= '0;
         BUSY         <= 1'b0;
         DONE         <= 1'b0;
`ifdef AUTOCONFIG_SERIAL_EN
         serial       <= '0;
         CFG_SERIAL   <= '0;
`endif
      end else begin
         busReq    <= 1'b0;
         CFG_VALID <= 1'b0;
         case (state)
            StIdle: begin
               if (START) begin
                  BUSY        <= 1'b1;
                  DONE        <= 1'b0;
                  BOARD_COUNT <= '0;
                  nextBase    <= AC_FIRST_SLOT;
                  nib         <= NIB_TYPE;
                  faulty      <= 1'b0;
                  waitAck     <= 1'b0;
                  state       <= StReadRom;
               end
            end
            StReadRom: begin
               if (!waitAck) begin
                  busReq  <= 1'b1;
                  busRw   <= 1'b1;
                  busAddr <= AC_BASE_ADDR + {18'd0, nib};
                  waitAck <= 1'b1;
               end else if (busAck) begin
                  waitAck <= 1'b0;
                  if (busTimedOut) begin
                     // Silence at nibble 0 means the chain is exhausted
                     if (nib == NIB_TYPE) begin
                        state <= StFinish;
                     end else begin
                        faulty <= 1'b1;
                        state  <= StDecide;
                     end
                  end else begin
                     if (nib == NIB_TYPE + 5'd1) begin
                        sizeCode <= busRdata[2:0];
                     end
                     if (nib >= NIB_PRODUCT && nib <= NIB_PRODUCT + 5'd1) begin
                        product <= {product[3:0], ~busRdata};
                     end
                     if (nib >= NIB_MFG && nib <= NIB_MFG + 5'd3) begin
                        mfg <= {mfg[11:0], ~busRdata};
                     end
`ifdef AUTOCONFIG_SERIAL_EN
                     if (nib >= NIB_SERIAL) begin
                        serial <= {serial[27:0], ~busRdata};
                     end
`endif
                     if (nib == NIB_TYPE && busRdata[3:2] != 2'b11) begin
                        state <= StFinish;
                     end else if (nib == NibLast) begin
                        state <= StDecide;
                     end else begin
                        nib <= nib + 5'd1;
                     end
                  end
               end
            end
            StDecide: begin
               if (fits) begin
                  busAddr      <= AC_BASE_ADDR + {16'd0, AC_BASE_REG};
                  busWdata     <= aligned[3:0];
                  assignedBase <= aligned[3:0];
                  nextBase     <= placedEnd[3:0];
               end else begin
                  busAddr      <= AC_BASE_ADDR + {16'd0, AC_SHUTUP_REG};
                  busWdata     <= 4'h0;
                  assignedBase <= 4'h0;
               end
               state <= StWrite;
            end
            StWrite: begin
               if (!waitAck) begin
                  busReq  <= 1'b1;
                  busRw   <= 1'b0;
                  waitAck <= 1'b1;
               end else if (busAck) begin
                  waitAck <= 1'b0;
                  state   <= StReport;
               end
            end
            StReport: begin
               CFG_VALID   <= 1'b1;
               CFG_MFG     <= mfg;
               CFG_PRODUCT <= product;
               CFG_BASE    <= assignedBase;
`ifdef AUTOCONFIG_SERIAL_EN
               CFG_SERIAL  <= serial;
`endif
               BOARD_COUNT <= BOARD_COUNT + 4'd1;
               faulty      <= 1'b0;
               nib         <= NIB_TYPE;
               state       <= (BOARD_COUNT + 4'd1 == MaxCount) ? StFinish : StReadRom;
            end
            StFinish: begin
               DONE  <= 1'b1;
               BUSY  <= 1'b0;
               state <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_autoconfig_master.sv
// Bench for autoconfig_master: behavioural board-chain slave plus a spec-level placement model.
module tb_autoconfig_master;

   localparam int MaxBoards = 8;

   logic        clk = 1'b0;
   logic        rstN = 1'b0;
   logic        start = 1'b0;
   logic        cfgValid;
   logic [15:0] cfgMfg;
   logic [7:0]  cfgProduct;
   logic [3:0]  cfgBase;
   logic [31:0] cfgSerial;
   logic [3:0]  boardCount;
   logic        busy;
   logic        done;

   autoconfig_master_if busIf ();

   autoconfig_master #(
      .MAX_BOARDS   (MaxBoards),
      .DTACK_TIMEOUT(255)
   ) dut (
      .CLK        (clk),
      .RESET_n    (rstN),
      .START      (start),
      .bus        (busIf),
      .CFG_VALID  (cfgValid),
      .CFG_MFG    (cfgMfg),
      .CFG_PRODUCT(cfgProduct),
      .CFG_BASE   (cfgBase),
      .CFG_SERIAL (cfgSerial),
      .BOARD_COUNT(boardCount),
      .BUSY       (busy),
      .DONE       (done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Board chain seen by the slave model
   logic [7:0]  bType [16];
   logic [7:0]  bProd [16];
   logic [15:0] bMfg  [16];
   logic [31:0] bSer  [16];
   int          bDelay[16];
   int          nBoards = 0;

   int          boardIdx = 0;
   int          dly = 0;
   int          asLow = 0;
   bit          seen = 0;
   bit          advance = 0;
   logic [22:0] readLog [$];
   logic [26:0] writeLog[$];
   logic [59:0] cfgLog  [$];

   logic [22:0] expReads [$];
   logic [26:0] expWrites[$];
   logic [59:0] expCfg   [$];
   int          expCount;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ROM image: type, product, flags, reserved, mfg, serial; nibbles >= 2 read back inverted
   function automatic logic [3:0] romNibble(input int b, input int n);
      logic [79:0] img;
      logic [3:0]  v;
      if (n < 0 || n > 19) return 4'hF;
      img = {bType[b], bProd[b], 8'h00, 8'h00, bMfg[b], bSer[b]};
      v = img[79 - 4*n -: 4];
      return (n >= 2) ? ~v : v;
   endfunction

   always @(negedge clk) begin
      if (!busIf.AS_n) asLow++;
      if (!busIf.AS_n && !busIf.UDS_n) begin
         if (!seen) begin
            seen = 1;
            dly = 0;
            if (busIf.RW) begin
               readLog.push_back(busIf.ADDRESS);
            end else begin
               writeLog.push_back({busIf.ADDRESS, busIf.DATA_OUT});
               advance = (busIf.ADDRESS == 23'h740024) || (busIf.ADDRESS == 23'h740026);
            end
         end
         if (boardIdx < nBoards) begin
            if (dly >= bDelay[boardIdx]) begin
               busIf.DTACK_n = 1'b0;
               if (busIf.RW) busIf.DATA_IN = romNibble(boardIdx, int'(busIf.ADDRESS - 23'h740000));
            end else begin
               dly++;
            end
         end
      end else begin
         busIf.DTACK_n = 1'b1;
         if (seen && advance) boardIdx++;
         seen = 0;
         advance = 0;
      end
   end

   always @(negedge clk) begin
      if (cfgValid === 1'b1) cfgLog.push_back({cfgMfg, cfgProduct, cfgBase, cfgSerial});
   end

   task automatic resetSlave();
      boardIdx = 0;
      dly = 0;
      asLow = 0;
      seen = 0;
      advance = 0;
      readLog.delete();
      writeLog.delete();
      cfgLog.delete();
      busIf.DTACK_n = 1'b1;
      busIf.DATA_IN = 4'h0;
   endtask

   task automatic doReset();
      @(negedge clk);
      rstN = 1'b0;
      repeat (2) @(negedge clk);
      rstN = 1'b1;
      resetSlave();
   endtask

   task automatic setBoard(input int i, input logic [7:0] t, input logic [7:0] p,
                           input logic [15:0] m, input logic [31:0] s, input int d);
      bType[i] = t;
      bProd[i] = p;
      bMfg[i] = m;
      bSer[i] = s;
      bDelay[i] = d;
   endtask

   // Placement model from the rules: natural alignment inside slots 2..9
   task automatic buildExpected();
      int nextB, cnt, slots, base, lastNib;
      logic [31:0] ser;
`ifdef AUTOCONFIG_SERIAL_EN
      lastNib = 19;
`else
      lastNib = 11;
`endif
      expReads.delete();
      expWrites.delete();
      expCfg.delete();
      nextB = 2;
      cnt = 0;
      for (int b = 0; b < 16; b++) begin
         if (cnt == MaxBoards) break;
         if (b >= nBoards || bType[b][7:6] != 2'b11) begin
            expReads.push_back(23'h740000);
            break;
         end
         for (int n = 0; n <= lastNib; n++) expReads.push_back(23'h740000 + 23'(n));
         case (bType[b][2:0])
            3'b000:  slots = 0;
            3'b110:  slots = 2;
            3'b111:  slots = 4;
            default: slots = 1;
         endcase
         base = (slots == 0) ? 0 : ((nextB + slots - 1) / slots) * slots;
         if (slots != 0 && base + slots <= 10) begin
            nextB = base + slots;
            expWrites.push_back({23'h740024, 4'(base)});
         end else begin
            base = 0;
            expWrites.push_back({23'h740026, 4'h0});
         end
`ifdef AUTOCONFIG_SERIAL_EN
         ser = bSer[b];
`else
         ser = 32'h0;
`endif
         expCfg.push_back({bMfg[b], bProd[b], 4'(base), ser});
         cnt++;
      end
      expCount = cnt;
   endtask

   task automatic runAndWait(input int budget);
      int cyc;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", {63'd0, busy}, 64'd1);
      cyc = 0;
      while (done !== 1'b1 && cyc < budget) begin
         @(negedge clk);
         cyc++;
         // A second START mid-run must be ignored
         start = (cyc == 30 && busy === 1'b1);
      end
      start = 1'b0;
      check("done", {63'd0, done}, 64'd1);
   endtask

   task automatic compareResults(input string name);
      int bad;
      check({name, "_board_count"}, 64'(boardCount), 64'(expCount));
      check({name, "_busy_idle"}, {63'd0, busy}, 64'd0);
      check({name, "_cfg_count"}, 64'(cfgLog.size()), 64'(expCfg.size()));
      for (int i = 0; i < cfgLog.size() && i < expCfg.size(); i++)
         check($sformatf("%s_cfg%0d", name, i), 64'(cfgLog[i]), 64'(expCfg[i]));
      check({name, "_read_count"}, 64'(readLog.size()), 64'(expReads.size()));
      bad = 0;
      for (int i = 0; i < readLog.size() && i < expReads.size(); i++)
         if (readLog[i] !== expReads[i]) bad++;
      check({name, "_read_addr_mismatches"}, 64'(bad), 64'd0);
      check({name, "_write_count"}, 64'(writeLog.size()), 64'(expWrites.size()));
      bad = 0;
      for (int i = 0; i < writeLog.size() && i < expWrites.size(); i++)
         if (writeLog[i] !== expWrites[i]) bad++;
      check({name, "_write_mismatches"}, 64'(bad), 64'd0);
   endtask

   task automatic scenarioOne(input string name);
      nBoards = 1;
      setBoard(0, 8'hC5, 8'd104, 16'h07B9, 32'h00003040, 1);
      buildExpected();
      runAndWait(20000);
      compareResults(name);
      check({name, "_mfg"}, 64'(cfgMfg), 64'h07B9);
      check({name, "_product"}, 64'(cfgProduct), 64'd104);
      check({name, "_base"}, 64'(cfgBase), 64'd2);
      check({name, "_count"}, 64'(boardCount), 64'd1);
`ifdef AUTOCONFIG_SERIAL_EN
      check({name, "_serial"}, 64'(cfgSerial), 64'h00003040);
      check({name, "_reads"}, 64'(readLog.size()), 64'd21);
`else
      check({name, "_serial"}, 64'(cfgSerial), 64'h0);
      check({name, "_reads"}, 64'(readLog.size()), 64'd13);
`endif
      if (writeLog.size() > 0) check({name, "_write0"}, 64'(writeLog[0]), {37'd0, 23'h740024, 4'h2});
   endtask

   initial begin
      int waitCyc;
      busIf.DTACK_n = 1'b1;
      busIf.DATA_IN = 4'h0;
      repeat (3) @(negedge clk);
      // Reset state
      check("rst_as", {63'd0, busIf.AS_n}, 64'd1);
      check("rst_uds", {63'd0, busIf.UDS_n}, 64'd1);
      check("rst_rw", {63'd0, busIf.RW}, 64'd1);
      check("rst_oe", {63'd0, busIf.DATA_OE}, 64'd0);
      check("rst_addr", 64'(busIf.ADDRESS), 64'd0);
      check("rst_status", {58'd0, boardCount, busy, done}, 64'd0);
      rstN = 1'b1;
      resetSlave();

      // Single board
      scenarioOne("single");

      // 2M then 1M board, then the chain runs dry
      doReset();
      nBoards = 2;
      setBoard(0, 8'hC6, 8'h11, 16'h1234, 32'hDEADBEEF, 0);
      setBoard(1, 8'hC5, 8'h22, 16'h5678, 32'h01020304, 2);
      buildExpected();
      runAndWait(20000);
      compareResults("chain");
      if (cfgLog.size() == 2) begin
         check("chain_base0", 64'(cfgLog[0][35:32]), 64'd2);
         check("chain_base1", 64'(cfgLog[1][35:32]), 64'd4);
      end
      check("chain_count", 64'(boardCount), 64'd2);

      // 8M board is shut up and does not consume space
      doReset();
      nBoards = 2;
      setBoard(0, 8'hC0, 8'h33, 16'h0ABC, 32'h11111111, 0);
      setBoard(1, 8'hC5, 8'h44, 16'h0DEF, 32'h22222222, 0);
      buildExpected();
      runAndWait(20000);
      compareResults("big");
      if (cfgLog.size() == 2) begin
         check("big_base0", 64'(cfgLog[0][35:32]), 64'd0);
         check("big_base1", 64'(cfgLog[1][35:32]), 64'd2);
      end
      if (writeLog.size() > 0) check("big_shutup", 64'(writeLog[0]), {37'd0, 23'h740026, 4'h0});

      // Slow DTACK still delivers correct data
      doReset();
      nBoards = 1;
      setBoard(0, 8'hC7, 8'h5A, 16'hBEEF, 32'hCAFEF00D, 40);
      buildExpected();
      runAndWait(30000);
      compareResults("slow");

      // No DTACK at all
      doReset();
      nBoards = 0;
      buildExpected();
      runAndWait(2000);
      compareResults("hang");
      check("hang_count", 64'(boardCount), 64'd0);
      check("hang_as_low_window", {63'd0, asLow >= 255 && asLow <= 260}, 64'd1);

      // Reset asserted while waiting for DTACK
      doReset();
      nBoards = 1;
      setBoard(0, 8'hC5, 8'd104, 16'h07B9, 32'h00003040, 200);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      waitCyc = 0;
      while (!(busIf.AS_n === 1'b0 && busIf.UDS_n === 1'b0) && waitCyc < 100) begin
         @(negedge clk);
         waitCyc++;
      end
      check("wait_strobes_low", {62'd0, busIf.AS_n, busIf.UDS_n}, 64'd0);
      repeat (5) @(negedge clk);
      #2 rstN = 1'b0;
      #1;
      check("async_as", {63'd0, busIf.AS_n}, 64'd1);
      check("async_uds", {63'd0, busIf.UDS_n}, 64'd1);
      check("async_bus", {36'd0, busIf.RW, busIf.DATA_OE, busIf.ADDRESS, busIf.DATA_OUT},
            {36'd0, 1'b1, 1'b0, 23'd0, 4'd0});
      check("async_status", {58'd0, boardCount, busy, done}, 64'd0);
      check("async_cfg", {cfgMfg, cfgProduct, cfgBase, 1'b0, cfgValid, 34'd0}, 64'd0);
      check("async_serial", 64'(cfgSerial), 64'd0);
      @(negedge clk);
      rstN = 1'b1;
      resetSlave();
      scenarioOne("after_reset");

      // Randomised chains, some longer than MAX_BOARDS, some ending on a bad type
      for (int r = 0; r < 6; r++) begin
         doReset();
         nBoards = $urandom_range(1, 10);
         for (int i = 0; i < nBoards; i++) begin
            setBoard(i, {2'b11, 3'($urandom), 3'($urandom_range(0, 7))}, 8'($urandom),
                     16'($urandom), $urandom, $urandom_range(0, 4));
            if ($urandom_range(0, 9) == 0) bType[i][7:6] = 2'b01;
         end
         buildExpected();
         runAndWait(40000);
         compareResults($sformatf("rand%0d", r));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
